// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle ops on c, iterative shift/add multiply and restoring divide on hi/lo.
// Latency: single-cycle ops and divide-by-zero 1 cycle; MUL/DIV WIDTH+2 cycles from start to done.
// Backpressure: busy is high while an iterative op runs; start is ignored (not queued) unless idle.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ovf,
  output logic             dz,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_LUI  = 4'd5;
  localparam logic [3:0] OP_MULU = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  // Iteration state: acc_hi is partial product / remainder, acc_lo is multiplier / quotient.
  logic [CNTW-1:0]    cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opb;
  logic               op_div, neg_q, neg_r;

  logic               is_mul, is_div, is_sgn, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   add_res, sub_res, alu_res;
  logic               add_ovf, sub_ovf;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign is_mul = (aluop == OP_MULU) || (aluop == OP_MUL);
  assign is_div = (aluop == OP_DIVU) || (aluop == OP_DIV);
  assign is_sgn = (aluop == OP_MUL) || (aluop == OP_DIV);
  assign b_zero = (b == '0);

  // Signed ops iterate on magnitudes; the sign is restored in FIX.
  assign mag_a = (is_sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_sgn && b[WIDTH-1]) ? -b : b;

  assign add_res = a + b;
  assign sub_res = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);

  // One shift/add multiply step and one restoring-subtract divide step.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -acc_lo : acc_lo;
  assign r_fix    = neg_r ? -acc_hi : acc_hi;

  assign busy = (state != IDLE);

  // Single-cycle result select; unknown opcodes produce zero.
  always_comb begin
    alu_res = '0;
    case (aluop)
      OP_ADD:  alu_res = add_res;
      OP_SUB:  alu_res = sub_res;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: iterative ops enter CALC, divide-by-zero completes from IDLE, flush aborts.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && (is_mul || (is_div && !b_zero))) state_nxt = CALC;
      end
      CALC: begin
        if (flush)            state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      c      <= '0;
      hi     <= '0;
      lo     <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul || (is_div && !b_zero)) begin
              acc_hi <= '0;
              acc_lo <= is_mul ? mag_b : mag_a;
              opb    <= is_mul ? mag_a : mag_b;
              op_div <= is_div;
              neg_q  <= is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= is_sgn && a[WIDTH-1];
              cnt    <= CNTW'(WIDTH - 1);
            end else if (is_div) begin
              dz   <= 1'b1;
              lo   <= '1;
              hi   <= a;
              done <= 1'b1;
            end else begin
              c <= alu_res;
              if (aluop == OP_ADD) ovf <= add_ovf;
              if (aluop == OP_SUB) ovf <= sub_ovf;
              done <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            cnt <= cnt - 1'b1;
            if (op_div) begin
              if (div_diff[WIDTH]) begin
                acc_hi <= div_sh[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
              end else begin
                acc_hi <= div_diff[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
              end
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          if (!flush) begin
            if (op_div) begin
              hi <= r_fix;
              lo <= q_fix;
              dz <= 1'b0;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv, running the same vector list on a 32-bit and an 8-bit instance.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived per width using the mask m (all ones) and top (sign bit).
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [3:0]  aluop;
  logic [31:0] a, b;

  logic [31:0] c32, hi32, lo32;
  logic        ovf32, dz32, busy32, done32;
  logic [7:0]  c8, hi8, lo8;
  logic        ovf8, dz8, busy8, done8;

  logic        sel;
  int          w;
  logic [31:0] m, top;
  logic [31:0] c_o, hi_o, lo_o;
  logic        ovf_o, dz_o, busy_o, done_o;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .a(a), .b(b), .flush(flush),
    .c(c32), .hi(hi32), .lo(lo32), .ovf(ovf32), .dz(dz32), .busy(busy32), .done(done32)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .a(a[7:0]), .b(b[7:0]), .flush(flush),
    .c(c8), .hi(hi8), .lo(lo8), .ovf(ovf8), .dz(dz8), .busy(busy8), .done(done8)
  );

  always_comb begin
    if (sel) begin
      c_o = {24'b0, c8};   hi_o = {24'b0, hi8};   lo_o = {24'b0, lo8};
      ovf_o = ovf8;        dz_o = dz8;            busy_o = busy8;  done_o = done8;
    end else begin
      c_o = c32;           hi_o = hi32;           lo_o = lo32;
      ovf_o = ovf32;       dz_o = dz32;           busy_o = busy32; done_o = done32;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL w=%0d %s: got 0x%0h expected 0x%0h", w, tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle, then wait (bounded) for done; returns latency and busy cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output int bc);
    aluop = op; a = aa; b = bb; start = 1'b1;
    tick();
    start = 1'b0; a = ~aa; b = ~bb;
    lat = 1;
    bc  = busy_o ? 1 : 0;
    while (done_o !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      if (busy_o) bc++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_c"},    c_o, 32'd0);
    check({tag, "_hi"},   hi_o, 32'd0);
    check({tag, "_lo"},   lo_o, 32'd0);
    check({tag, "_ovf"},  32'(ovf_o), 32'd0);
    check({tag, "_dz"},   32'(dz_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  task automatic run_plan();
    int lat, bc, n, dn, fl;
    rst = 1'b1; start = 1'b0; flush = 1'b0; aluop = 4'd0; a = '0; b = '0;
    tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // ADD overflow at the positive limit.
    run_op(4'd0, top - 1, 32'd1, lat, bc);
    check("add_lat", lat, 32'd1);
    check("add_busy", bc, 32'd0);
    check("add_c", c_o, top);
    check("add_ovf", 32'(ovf_o), 32'd1);
    tick();
    check("add_done_pulse", 32'(done_o), 32'd0);
    check("add_c_hold", c_o, top);

    run_op(4'd4, m, 32'd1, lat, bc);
    check("slt_c", c_o, 32'd1);
    check("slt_ovf_kept", 32'(ovf_o), 32'd1);

    run_op(4'd1, 32'd0, 32'd1, lat, bc);
    check("sub_c", c_o, m);
    check("sub_ovf", 32'(ovf_o), 32'd0);

    run_op(4'd1, top, 32'd1, lat, bc);
    check("sub_ovf_c", c_o, top - 1);
    check("sub_ovf_ovf", 32'(ovf_o), 32'd1);

    run_op(4'd2, 32'hC3A5_5A3C & m, 32'h0FF0_F00F & m, lat, bc);
    check("and_c", c_o, 32'h03A0_500C & m);

    run_op(4'd5, 32'd0, 32'h1234_ABCD & m, lat, bc);
    check("lui_c", c_o, (w == 32) ? 32'hABCD_0000 : 32'h0000_00D0);

    run_op(4'd15, 32'd5, 32'd5, lat, bc);
    check("undef_lat", lat, 32'd1);
    check("undef_c", c_o, 32'd0);

    run_op(4'd3, 32'hC3A5_5A3C & m, 32'h0FF0_F00F & m, lat, bc);
    check("or_c", c_o, 32'hCFF5_FA3F & m);

    run_op(4'd13, m, m, lat, bc);
    check("zero_c", c_o, 32'd0);
    check("zero_ovf_kept", 32'(ovf_o), 32'd1);

    // Signed multiply -3 * 7 = -21.
    run_op(4'd7, m - 2, 32'd7, lat, bc);
    check("mul_lat", lat, 32'(w + 2));
    check("mul_busy_cycles", bc, 32'(w + 1));
    check("mul_busy_done", 32'(busy_o), 32'd0);
    check("mul_hi", hi_o, m);
    check("mul_lo", lo_o, m - 20);
    check("mul_c_hold", c_o, 32'd0);
    tick();
    check("mul_done_pulse", 32'(done_o), 32'd0);

    run_op(4'd6, m, m, lat, bc);
    check("mulu_hi", hi_o, m - 1);
    check("mulu_lo", lo_o, 32'd1);

    // Signed divides: -7/2 = -3 r -1, 7/-2 = -3 r 1.
    run_op(4'd9, m - 6, 32'd2, lat, bc);
    check("div_lat", lat, 32'(w + 2));
    check("div_lo", lo_o, m - 2);
    check("div_hi", hi_o, m);
    run_op(4'd9, 32'd7, m - 1, lat, bc);
    check("div2_lo", lo_o, m - 2);
    check("div2_hi", hi_o, 32'd1);

    run_op(4'd8, 32'd5, 32'd0, lat, bc);
    check("dz_lat", lat, 32'd1);
    check("dz_busy", bc, 32'd0);
    check("dz_lo", lo_o, m);
    check("dz_hi", hi_o, 32'd5);
    check("dz_flag", 32'(dz_o), 32'd1);

    run_op(4'd8, 32'd100, 32'd7, lat, bc);
    check("divu_lat", lat, 32'(w + 2));
    check("divu_lo", lo_o, 32'd14);
    check("divu_hi", hi_o, 32'd2);
    check("divu_dz", 32'(dz_o), 32'd0);

    // Flush mid-multiply, with an ignored start while busy.
    fl = (w > 10) ? 10 : 5;
    dn = 0;
    aluop = 4'd7; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    if (done_o) dn++;
    while (n < fl) begin
      if (n == 3) begin aluop = 4'd0; a = 32'd1; b = 32'd1; start = 1'b1; end
      tick();
      start = 1'b0;
      n++;
      if (done_o) dn++;
    end
    check("fl_busy_before", 32'(busy_o), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", 32'(busy_o), 32'd0);
    check("fl_c_ignored", c_o, 32'd0);
    for (int i = 0; i < w + 4; i++) begin
      tick();
      if (done_o) dn++;
    end
    check("fl_no_done", dn, 32'd0);
    check("fl_hi", hi_o, 32'd2);
    check("fl_lo", lo_o, 32'd14);

    // Reset in the middle of a divide.
    run_op(4'd1, top, 32'd1, lat, bc);
    check("pre_rst_c", c_o, top - 1);
    aluop = 4'd8; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("rst_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midrst");
    tick();
    check("midrst_idle", 32'(busy_o), 32'd0);

    // Back-to-back: ADD started in the MUL done cycle.
    run_op(4'd7, 32'd6, 32'd7, lat, bc);
    check("b2b_mul_lat", lat, 32'(w + 2));
    check("b2b_mul_lo", lo_o, 32'd42);
    check("b2b_mul_hi", hi_o, 32'd0);
    run_op(4'd0, 32'd2, 32'd3, lat, bc);
    check("b2b_add_lat", lat, 32'd1);
    check("b2b_add_c", c_o, 32'd5);
    check("b2b_add_ovf", 32'(ovf_o), 32'd0);
    check("b2b_lo_hold", lo_o, 32'd42);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; aluop = 4'd0; a = '0; b = '0;
    sel = 1'b0; w = 32; m = 32'hFFFF_FFFF; top = 32'h8000_0000;
    run_plan();
    sel = 1'b1; w = 8; m = 32'h0000_00FF; top = 32'h0000_0080;
    run_plan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
